// File: rtl/peak_dpu_pkg.sv
// Shared DPU definitions: load/store op encodings, LSU FSM states, byte-enable
// constants and small op-classification helpers.
package peak_dpu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } ls_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_FIN  = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_store(input ls_op_e op);
        logic res;
        case (op)
            OP_SB, OP_SH, OP_SW: res = 1'b1;
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input ls_op_e op, input logic [1:0] ea_lo);
        logic res;
        case (op)
            OP_LH, OP_LHU, OP_SH: res = ea_lo[0];
            OP_LW, OP_SW:         res = (ea_lo != 2'b00);
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/peak_dpu_lsu_align.sv
// Combinational lane logic: store replication / byte enables and load lane
// extraction with sign or zero extension.
module peak_dpu_lsu_align
    import peak_dpu_pkg::*;
(
    input  ls_op_e      op,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] st_src,
    input  logic [31:0] ld_src,
    output logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store data steering and byte-enable generation
    always_comb begin
        st_data = 32'h0000_0000;
        be      = BE_NONE;
        case (op)
            OP_LB, OP_LBU: be = BE_BYTE0 << ea_lo;
            OP_LH, OP_LHU: be = ea_lo[1] ? BE_HI_HALF : BE_LO_HALF;
            OP_LW:         be = BE_WORD;
            OP_SB: begin
                st_data = {4{st_src[7:0]}};
                be      = BE_BYTE0 << ea_lo;
            end
            OP_SH: begin
                st_data = {2{st_src[15:0]}};
                be      = ea_lo[1] ? BE_HI_HALF : BE_LO_HALF;
            end
            OP_SW: begin
                st_data = st_src;
                be      = BE_WORD;
            end
            default: begin
                st_data = 32'h0000_0000;
                be      = BE_NONE;
            end
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        case (ea_lo)
            2'd0:    byte_s = ld_src[7:0];
            2'd1:    byte_s = ld_src[15:8];
            2'd2:    byte_s = ld_src[23:16];
            2'd3:    byte_s = ld_src[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = ea_lo[1] ? ld_src[31:16] : ld_src[15:0];
        case (op)
            OP_LB:   ld_data = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  ld_data = {24'h00_0000, byte_s};
            OP_LH:   ld_data = {{16{half_s[15]}}, half_s};
            OP_LHU:  ld_data = {16'h0000, half_s};
            OP_LW:   ld_data = ld_src;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/peak_dpu_lsu.sv
// DPU load/store unit: EA computation, single-outstanding req/gnt/rsp port,
// load writeback and exception pulses. Optional macro PEAK_DPU_LSU_TIMEOUT_EN
// adds a response-wait timeout of TIMEOUT_CYC cycles.
module peak_dpu_lsu
    import peak_dpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_vld,
    output logic        ls_rdy,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_base,
    input  logic [31:0] ls_imm,
    input  logic [31:0] ls_wdata,
    input  logic [4:0]  ls_wr_addr,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvld,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        wb_vld,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_bus_err,
    output logic [31:0] exc_addr
);

    lsu_state_e  state_q, state_d;
    ls_op_e      op_q, op_d, op_in_s, op_sel_s;
    logic [31:0] ea_q, ea_d, ea_s;
    logic [4:0]  rd_q, rd_d;
    logic        ls_rdy_q, ls_rdy_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        wb_vld_q, wb_vld_d, exc_mis_q, exc_mis_d, exc_bus_q, exc_bus_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d, exc_addr_q, exc_addr_d;
    logic [31:0] st_data_s, ld_data_s;
    logic [3:0]  be_s;
    logic [1:0]  ea_lo_sel_s;

`ifdef PEAK_DPU_LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign ea_s        = ls_base + ls_imm;
    assign op_in_s     = ls_op_e'(ls_op);
    // While idle the aligner steers the incoming op; afterwards it extracts the latched load
    assign op_sel_s    = (state_q == ST_IDLE) ? op_in_s : op_q;
    assign ea_lo_sel_s = (state_q == ST_IDLE) ? ea_s[1:0] : ea_q[1:0];

    peak_dpu_lsu_align u_align (
        .op      (op_sel_s),
        .ea_lo   (ea_lo_sel_s),
        .st_src  (ls_wdata),
        .ld_src  (mem_rdata),
        .st_data (st_data_s),
        .be      (be_s),
        .ld_data (ld_data_s)
    );

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ea_d        = ea_q;
        rd_d        = rd_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_vld_d    = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        exc_mis_d   = 1'b0;
        exc_bus_d   = 1'b0;
        exc_addr_d  = exc_addr_q;
`ifdef PEAK_DPU_LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ls_vld) begin
                    if (is_misaligned(op_in_s, ea_s[1:0])) begin
                        exc_mis_d  = 1'b1;
                        exc_addr_d = ea_s;
                        state_d    = ST_FIN;
                    end else begin
                        op_d        = op_in_s;
                        ea_d        = ea_s;
                        rd_d        = ls_wr_addr;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {ea_s[31:2], 2'b00};
                        mem_we_d    = is_store(op_in_s);
                        mem_be_d    = be_s;
                        mem_wdata_d = st_data_s;
                        state_d     = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RSP;
`ifdef PEAK_DPU_LSU_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RSP: begin
                if (mem_rvld) begin
                    state_d = ST_FIN;
                    if (mem_err) begin
                        exc_bus_d  = 1'b1;
                        exc_addr_d = ea_q;
                    end else if (!is_store(op_q)) begin
                        wb_vld_d  = 1'b1;
                        wb_addr_d = rd_q;
                        wb_data_d = ld_data_s;
                    end else begin
                        wb_vld_d = 1'b0;
                    end
`ifdef PEAK_DPU_LSU_TIMEOUT_EN
                // This is the TIMEOUT_CYC-th silent RSP cycle
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    exc_bus_d  = 1'b1;
                    exc_addr_d = ea_q;
                    state_d    = ST_FIN;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`else
                end else begin
                    state_d = ST_RSP;
`endif
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ls_rdy_d = (state_d == ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LB;
            ea_q        <= 32'h0000_0000;
            rd_q        <= 5'd0;
            ls_rdy_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_we_q    <= 1'b0;
            mem_be_q    <= BE_NONE;
            mem_wdata_q <= 32'h0000_0000;
            wb_vld_q    <= 1'b0;
            wb_addr_q   <= 5'd0;
            wb_data_q   <= 32'h0000_0000;
            exc_mis_q   <= 1'b0;
            exc_bus_q   <= 1'b0;
            exc_addr_q  <= 32'h0000_0000;
`ifdef PEAK_DPU_LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ea_q        <= ea_d;
            rd_q        <= rd_d;
            ls_rdy_q    <= ls_rdy_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_vld_q    <= wb_vld_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            exc_mis_q   <= exc_mis_d;
            exc_bus_q   <= exc_bus_d;
            exc_addr_q  <= exc_addr_d;
`ifdef PEAK_DPU_LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign ls_rdy       = ls_rdy_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_vld       = wb_vld_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign exc_misalign = exc_mis_q;
    assign exc_bus_err  = exc_bus_q;
    assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_peak_dpu_lsu.sv
// Self-checking bench for peak_dpu_lsu: table of directed ops plus hand-written
// reset-in-flight and (when PEAK_DPU_LSU_TIMEOUT_EN is defined) timeout sequences.
module tb_peak_dpu_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ls_vld, ls_rdy;
    logic [2:0]  ls_op;
    logic [31:0] ls_base, ls_imm, ls_wdata;
    logic [4:0]  ls_wr_addr;
    logic        mem_req, mem_gnt, mem_we, mem_rvld, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_vld, exc_misalign, exc_bus_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, exc_addr;

    int checks = 0;
    int errors = 0;

`ifdef PEAK_DPU_LSU_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    peak_dpu_lsu #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .ls_vld(ls_vld), .ls_rdy(ls_rdy), .ls_op(ls_op), .ls_base(ls_base),
        .ls_imm(ls_imm), .ls_wdata(ls_wdata), .ls_wr_addr(ls_wr_addr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvld(mem_rvld),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_bus_err(exc_bus_err), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          gnt_dly;
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] sdata;
        logic        wb;
        logic [31:0] wbd;
        logic [31:0] ea;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm,
                                input logic [31:0] wdata, input int gdly, input logic [31:0] rdata,
                                input logic err, input logic mis, input logic [31:0] addr,
                                input logic [3:0] be, input logic we, input logic [31:0] sdata,
                                input logic wb, input logic [31:0] wbd, input logic [31:0] ea);
        vec_t v;
        v.op = op; v.base = base; v.imm = imm; v.wdata = wdata; v.rd = 5'd0 + 5'(op) + 5'd3;
        v.gnt_dly = gdly; v.rdata = rdata; v.err = err; v.mis = mis; v.addr = addr;
        v.be = be; v.we = we; v.sdata = sdata; v.wb = wb; v.wbd = wbd; v.ea = ea;
        return v;
    endfunction

    task automatic idle_inputs();
        ls_vld = 1'b0; ls_op = 3'd0; ls_base = 32'h0; ls_imm = 32'h0;
        ls_wdata = 32'h0; ls_wr_addr = 5'd0;
        mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    endtask

    task automatic check_req(input vec_t v, input string tag);
        chk({tag, " mem_req"}, {31'h0, mem_req}, 32'h1);
        chk({tag, " mem_addr"}, mem_addr, v.addr);
        chk({tag, " mem_be"}, {28'h0, mem_be}, {28'h0, v.be});
        chk({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, v.we});
        if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.sdata);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int lat;
        v = vecs[i];
        @(negedge clk);
        chk($sformatf("v%0d ls_rdy_pre", i), {31'h0, ls_rdy}, 32'h1);
        ls_vld = 1'b1; ls_op = v.op; ls_base = v.base; ls_imm = v.imm;
        ls_wdata = v.wdata; ls_wr_addr = v.rd;
        @(negedge clk);
        idle_inputs();
        lat = 1;
        if (v.mis) begin
            chk($sformatf("v%0d exc_misalign", i), {31'h0, exc_misalign}, 32'h1);
            chk($sformatf("v%0d exc_addr", i), exc_addr, v.ea);
            chk($sformatf("v%0d mis_no_req", i), {31'h0, mem_req}, 32'h0);
            chk($sformatf("v%0d mis_ls_rdy_low", i), {31'h0, ls_rdy}, 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d mis_pulse_end", i), {31'h0, exc_misalign}, 32'h0);
            chk($sformatf("v%0d mis_ls_rdy", i), {31'h0, ls_rdy}, 32'h1);
            chk($sformatf("v%0d mis_no_req2", i), {31'h0, mem_req}, 32'h0);
        end else begin
            check_req(v, $sformatf("v%0d", i));
            for (int d = 0; d < v.gnt_dly; d++) begin
                @(negedge clk);
                lat++;
                check_req(v, $sformatf("v%0d hold%0d", i, d));
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            lat++;
            mem_gnt = 1'b0;
            chk($sformatf("v%0d req_drop", i), {31'h0, mem_req}, 32'h0);
            mem_rvld = 1'b1; mem_rdata = v.rdata; mem_err = v.err;
            @(negedge clk);
            lat++;
            idle_inputs();
            chk($sformatf("v%0d wb_vld", i), {31'h0, wb_vld}, {31'h0, v.wb});
            chk($sformatf("v%0d exc_bus_err", i), {31'h0, exc_bus_err}, {31'h0, v.err});
            chk($sformatf("v%0d no_mis", i), {31'h0, exc_misalign}, 32'h0);
            if (v.wb) begin
                chk($sformatf("v%0d wb_data", i), wb_data, v.wbd);
                chk($sformatf("v%0d wb_addr", i), {27'h0, wb_addr}, {27'h0, v.rd});
                chk($sformatf("v%0d latency", i), lat, 3 + v.gnt_dly);
            end
            if (v.err) chk($sformatf("v%0d exc_addr", i), exc_addr, v.ea);
            @(negedge clk);
            chk($sformatf("v%0d ls_rdy_post", i), {31'h0, ls_rdy}, 32'h1);
            chk($sformatf("v%0d wb_pulse_end", i), {31'h0, wb_vld}, 32'h0);
            chk($sformatf("v%0d bus_pulse_end", i), {31'h0, exc_bus_err}, 32'h0);
        end
    endtask

    initial begin
        //             op    base          imm           wdata         dly rdata         err  mis  addr          be       we    sdata         wb    wbd           ea
        vecs[0]  = mk(3'd2, 32'h0000_1000, 32'h0000_0004, 32'h0,        0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_1004, 4'b1111, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 32'h0000_1004);
        vecs[1]  = mk(3'd0, 32'h0000_2000, 32'h0000_0003, 32'h0,        0, 32'h80FF_FFFF, 1'b0, 1'b0, 32'h0000_2000, 4'b1000, 1'b0, 32'h0,        1'b1, 32'hFFFF_FF80, 32'h0000_2003);
        vecs[2]  = mk(3'd3, 32'h0000_2000, 32'h0000_0003, 32'h0,        0, 32'h80FF_FFFF, 1'b0, 1'b0, 32'h0000_2000, 4'b1000, 1'b0, 32'h0,        1'b1, 32'h0000_0080, 32'h0000_2003);
        vecs[3]  = mk(3'd6, 32'h0000_3000, 32'h0000_0002, 32'h1234_ABCD, 0, 32'h0,        1'b0, 1'b0, 32'h0000_3000, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b0, 32'h0,        32'h0000_3002);
        vecs[4]  = mk(3'd2, 32'h0000_4000, 32'h0000_0001, 32'h0,        0, 32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_4001);
        vecs[5]  = mk(3'd1, 32'h0000_1FFE, 32'h0000_0003, 32'h0,        0, 32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_2001);
        vecs[6]  = mk(3'd1, 32'h0000_5000, 32'h0000_0002, 32'h0,        0, 32'h8001_7FFF, 1'b0, 1'b0, 32'h0000_5000, 4'b1100, 1'b0, 32'h0,        1'b1, 32'hFFFF_8001, 32'h0000_5002);
        vecs[7]  = mk(3'd4, 32'h0000_5000, 32'h0000_0000, 32'h0,        1, 32'h8001_F00F, 1'b0, 1'b0, 32'h0000_5000, 4'b0011, 1'b0, 32'h0,        1'b1, 32'h0000_F00F, 32'h0000_5000);
        vecs[8]  = mk(3'd5, 32'h0000_6000, 32'h0000_0001, 32'h0000_00A5, 0, 32'h0,        1'b0, 1'b0, 32'h0000_6000, 4'b0010, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0,        32'h0000_6001);
        vecs[9]  = mk(3'd7, 32'h0000_7000, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2, 32'h0,        1'b0, 1'b0, 32'h0000_6FFC, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,        32'h0000_6FFC);
        vecs[10] = mk(3'd2, 32'h0000_8000, 32'h0000_0008, 32'h0,        5, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0000_8008, 4'b1111, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_8008);
        vecs[11] = mk(3'd2, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,        0, 32'h1122_3344, 1'b0, 1'b0, 32'h0000_0004, 4'b1111, 1'b0, 32'h0,        1'b1, 32'h1122_3344, 32'h0000_0004);
        vecs[12] = mk(3'd0, 32'h0000_A000, 32'h0000_0001, 32'h0,        0, 32'h0000_7F00, 1'b0, 1'b0, 32'h0000_A000, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h0000_007F, 32'h0000_A001);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst ls_rdy", {31'h0, ls_rdy}, 32'h1);
        chk("rst mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst wb_vld", {31'h0, wb_vld}, 32'h0);
        chk("rst wb_data", wb_data, 32'h0);
        chk("rst exc", {30'h0, exc_misalign, exc_bus_err}, 32'h0);
        chk("rst exc_addr", exc_addr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset while waiting for grant, then a stray response
        @(negedge clk);
        ls_vld = 1'b1; ls_op = 3'd2; ls_base = 32'h0000_B000; ls_imm = 32'h0; ls_wr_addr = 5'd9;
        @(negedge clk);
        idle_inputs();
        chk("rstreq mem_req_before", {31'h0, mem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq mem_req_async", {31'h0, mem_req}, 32'h0);
        chk("rstreq ls_rdy_async", {31'h0, ls_rdy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        mem_rvld = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstreq no_wb%0d", k), {31'h0, wb_vld}, 32'h0);
            chk($sformatf("rstreq idle%0d", k), {31'h0, ls_rdy}, 32'h1);
            @(negedge clk);
        end

`ifdef PEAK_DPU_LSU_TIMEOUT_EN
        begin
            int waited;
            ls_vld = 1'b1; ls_op = 3'd2; ls_base = 32'h0000_C000; ls_imm = 32'h0000_0010;
            @(negedge clk);
            idle_inputs();
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            waited = 0;
            while (!exc_bus_err && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("timeout exc_bus_err", {31'h0, exc_bus_err}, 32'h1);
            chk("timeout cycles", waited, 4);
            chk("timeout exc_addr", exc_addr, 32'h0000_C010);
            chk("timeout no_wb", {31'h0, wb_vld}, 32'h0);
            @(negedge clk);
            chk("timeout ls_rdy", {31'h0, ls_rdy}, 32'h1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
